// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and helpers for the UART receiver with integrated receive FIFO.
// Optional parity support is enabled elsewhere by defining UART_RX_PARITY_EN.
package uart_pkg;

  // Nominal 25 MHz clock with a 17280 ns bit period.
  localparam int CLKS_PER_BIT_DEFAULT = 432;

  // Receiver states; PARITY is only reachable when parity support is compiled in.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_t;

  // Ceiling log2, used for sizing counters and pointers (clog2(1) == 0).
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Read-side bus of the UART receive FIFO plus receiver status pulses.
// parity_err exists only when UART_RX_PARITY_EN is defined.
//
// Handshake: the FIFO is first-word fall-through. rd_data is the head word and
// is valid whenever empty==0. Asserting rd_en in a cycle with empty==0 consumes
// that head word at the next rising edge; rd_en while empty==1 is ignored.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  import uart_pkg::*;

  localparam int CW = clog2(FIFO_DEPTH) + 1;

  logic                 rd_en;
  logic [DATA_BITS-1:0] rd_data;
  logic                 empty;
  logic                 full;
  logic [CW-1:0]        count;
  logic                 frame_err;
  logic                 overrun;
  logic                 rx_busy;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;
`endif
  // Receiver FSM state, exposed for observation.
  rx_state_t            state;

`ifdef UART_RX_PARITY_EN
  modport master (
    input  rd_en,
    output rd_data, empty, full, count, frame_err, overrun, rx_busy, parity_err, state
  );
  modport slave (
    output rd_en,
    input  rd_data, empty, full, count, frame_err, overrun, rx_busy, parity_err, state
  );
`else
  modport master (
    input  rd_en,
    output rd_data, empty, full, count, frame_err, overrun, rx_busy, state
  );
  modport slave (
    output rd_en,
    input  rd_data, empty, full, count, frame_err, overrun, rx_busy, state
  );
`endif

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word fall-through synchronous FIFO. Write is refused when full unless a
// pop happens in the same cycle; the caller derives any overrun indication.
module sync_fifo
  import uart_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 16,
  localparam int AW         = clog2(DEPTH),
  localparam int CW         = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [CW-1:0]         count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign do_rd = rd_en && !empty;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the write.
  assign do_wr = wr_en && (!full || do_rd);
  // Head word is forced to zero while empty so the output is defined after reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (start + DATA_BITS + optional parity + STOP_BITS, LSB first)
// feeding a first-word fall-through receive FIFO.
// Define UART_RX_PARITY_EN to add the parity bit, PARITY_ODD and parity_err.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter int PARITY_ODD   = 0
`endif
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rxd,
  uart_rx_fifo_if.master bus
);

  localparam int CNT_W = clog2(CLKS_PER_BIT);
  localparam int CW    = clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

  // Synchroniser and FSM state
  logic                 rx_meta;
  logic                 rxs;
  rx_state_t            state;
  rx_state_t            state_n;
  logic [CNT_W-1:0]     bit_cnt;
  logic [CNT_W-1:0]     cnt_n;
  logic [3:0]           bit_idx;
  logic [3:0]           idx_n;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_n;
  logic                 par_bad;
  logic                 par_bad_n;
  logic                 push_n;
  logic                 ferr_n;
`ifdef UART_RX_PARITY_EN
  logic                 perr_n;
  logic                 parity_err_q;
`endif

  // Registered outputs toward the FIFO and status pulses
  logic                 wr_en_q;
  logic [DATA_BITS-1:0] wr_data_q;
  logic                 frame_err_q;
  logic                 overrun_q;

  // FIFO side
  logic [DATA_BITS-1:0] fifo_rd_data;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [CW-1:0]        fifo_count;

  // Two-flop synchroniser on the asynchronous line, preset to the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  // FSM state, bit timer, index counter and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift_q <= '0;
      par_bad <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= cnt_n;
      bit_idx <= idx_n;
      shift_q <= shift_n;
      par_bad <= par_bad_n;
    end
  end

  // Next-state logic: mid-bit sampling, word assembly and error detection.
  always_comb begin
    state_n   = state;
    cnt_n     = bit_cnt + 1'b1;
    idx_n     = bit_idx;
    shift_n   = shift_q;
    par_bad_n = par_bad;
    push_n    = 1'b0;
    ferr_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_n    = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_n     = '0;
        idx_n     = '0;
        par_bad_n = 1'b0;
        if (!rxs) begin
          state_n = START;
        end
      end
      START: begin
        // Restarting the timer at mid start bit puts later samples mid-bit.
        if (bit_cnt == HALF_CNT) begin
          cnt_n   = '0;
          state_n = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_cnt == LAST_CNT) begin
          cnt_n   = '0;
          shift_n = {rxs, shift_q[DATA_BITS-1:1]};
          if (bit_idx == LAST_DATA) begin
            idx_n = '0;
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = bit_idx + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        // Data plus parity bit must have even (or odd) total weight.
        if (bit_cnt == LAST_CNT) begin
          cnt_n   = '0;
          state_n = STOP;
          if ((^shift_q ^ rxs) != 1'(PARITY_ODD)) begin
            par_bad_n = 1'b1;
            perr_n    = 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (bit_cnt == LAST_CNT) begin
          cnt_n = '0;
          if (!rxs) begin
            ferr_n  = 1'b1;
            state_n = WAIT_IDLE;
          end else if (bit_idx == LAST_STOP) begin
            push_n  = !par_bad;
            state_n = IDLE;
          end else begin
            idx_n = bit_idx + 1'b1;
          end
        end
      end
      WAIT_IDLE: begin
        // A held-low line (break) must return high before a new frame starts.
        cnt_n = '0;
        if (rxs) begin
          state_n = IDLE;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // Push request and status pulses, each registered for exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      wr_en_q     <= push_n;
      wr_data_q   <= shift_q;
      frame_err_q <= ferr_n;
      overrun_q   <= wr_en_q && fifo_full && !bus.rd_en;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity mismatch pulse, raised at the parity sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= perr_n;
    end
  end
  assign bus.parity_err = parity_err_q;
`endif

  sync_fifo #(
    .DATA_WIDTH (DATA_BITS),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_q),
    .wr_data (wr_data_q),
    .rd_en   (bus.rd_en),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign bus.rd_data   = fifo_rd_data;
  assign bus.empty     = fifo_empty;
  assign bus.full      = fifo_full;
  assign bus.count     = fifo_count;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.rx_busy   = (state == START) || (state == DATA) ||
                         (state == PARITY) || (state == STOP);
  assign bus.state     = state;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a fast instance (16 clk/bit) for FIFO and error
// scenarios and a default-parameter instance (432 clk/bit) for basic reception.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int CPB_D = 432;
  localparam int DEPTH = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PAR   = 1;
`else
  localparam int PAR   = 0;
`endif

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  logic rxd;
  logic rxd_def;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) bus ();
  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) bus_def ();

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .rxd (rxd),
    .bus (bus)
  );

  uart_rx_fifo dut_def (
    .clk (clk),
    .rst (rst),
    .rxd (rxd_def),
    .bus (bus_def)
  );

  // Scoreboard state
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int exp_ovr  = 0;
  int ferr_n   = 0;
  int ovr_n    = 0;
  int perr_n   = 0;
  int ferr_d   = 0;

  // Pulse monitors, sampled on the inactive edge.
  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) ferr_n++;
    if (bus.overrun === 1'b1) ovr_n++;
    if (bus_def.frame_err === 1'b1) ferr_d++;
`ifdef UART_RX_PARITY_EN
    if (bus.parity_err === 1'b1) perr_n++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_line(input bit sel, input logic v);
    if (sel) rxd_def = v;
    else     rxd     = v;
  endtask

  // One frame, LSB first. With pop set, rd_en is pulsed so that it is high at
  // the edge where the received word is written (HALF+4 edges into the stop bit).
  task automatic send_frame(input bit sel, input int cpb, input logic [7:0] data,
                            input bit stop_ok, input bit par_ok, input bit pop);
    logic [11:0] bits;
    int nb;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = data[i];
    nb = 9;
    if (PAR == 1) begin
      bits[nb] = (^data) ^ !par_ok;
      nb++;
    end
    bits[nb] = stop_ok;
    nb++;
    for (int b = 0; b < nb; b++) begin
      drive_line(sel, bits[b]);
      for (int c = 0; c < cpb; c++) begin
        if (pop && b == nb - 1 && c == cpb / 2 + 3) begin
          check("pop_head", bus.rd_data, (exp_q.size() > 0) ? exp_q[0] : 32'hFFFF_FFFF);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          bus.rd_en = 1'b1;
        end
        if (pop && b == nb - 1 && c == cpb / 2 + 4) bus.rd_en = 1'b0;
        @(negedge clk);
      end
    end
    if (stop_ok) drive_line(sel, 1'b1);
  endtask

  // Good frame into the fast instance; the queue itself models FIFO occupancy.
  task automatic send_good(input logic [7:0] d, input bit pop);
    if (exp_q.size() >= DEPTH && !pop) exp_ovr++;
    else exp_q.push_back(d);
    send_frame(1'b0, CPB, d, 1'b1, 1'b1, pop);
    repeat (4) @(negedge clk);
  endtask

  // Pop everything, comparing each head word with the scoreboard.
  task automatic drain(input string tag);
    int guard;
    guard = 0;
    @(negedge clk);
    while (bus.empty !== 1'b1 && guard < 40) begin
      check({tag, "_data"}, bus.rd_data, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF);
      bus.rd_en = 1'b1;
      @(negedge clk);
      bus.rd_en = 1'b0;
      guard++;
    end
    check({tag, "_left"}, exp_q.size(), 0);
    check({tag, "_empty"}, bus.empty, 1);
  endtask

  initial begin
    int f0;
    int o0;
    int p0;
    int x0;
    rst = 1'b1;
    rxd = 1'b1;
    rxd_def = 1'b1;
    bus.rd_en = 1'b0;
    bus_def.rd_en = 1'b0;
    repeat (4) @(negedge clk);

    // Reset state
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_count", bus.count, 0);
    check("rst_frame_err", bus.frame_err, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_busy", bus.rx_busy, 0);
    check("rst_def_empty", bus_def.empty, 1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1: default instance receives 0xA5, then one pop empties it
    send_frame(1'b1, CPB_D, 8'hA5, 1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("t1_rd_data", bus_def.rd_data, 8'hA5);
    check("t1_empty", bus_def.empty, 0);
    check("t1_count", bus_def.count, 1);
    bus_def.rd_en = 1'b1;
    @(negedge clk);
    bus_def.rd_en = 1'b0;
    check("t1_empty_after_pop", bus_def.empty, 1);

    // 2: 100-cycle low glitch is rejected at mid start bit
    x0 = ferr_d;
    rxd_def = 1'b0;
    repeat (50) @(negedge clk);
    check("t2_busy_high", bus_def.rx_busy, 1);
    repeat (50) @(negedge clk);
    rxd_def = 1'b1;
    repeat (250) @(negedge clk);
    check("t2_busy_low", bus_def.rx_busy, 0);
    check("t2_count", bus_def.count, 0);
    check("t2_ferr", ferr_d - x0, 0);

    // 3: bad stop bit, long break, then a clean 0x5A
    f0 = ferr_n;
    send_frame(1'b0, CPB, 8'h3C, 1'b0, 1'b1, 1'b0);
    repeat (2000) @(negedge clk);
    check("t3_ferr", ferr_n - f0, 1);
    check("t3_count", bus.count, 0);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    send_good(8'h5A, 1'b0);
    drain("t3");

    // 4: 17 bytes with no reads: full after 16, overrun on the 17th
    o0 = ovr_n;
    exp_ovr = 0;
    for (int i = 0; i < 17; i++) begin
      send_good(8'(i), 1'b0);
      if (i == 15) begin
        check("t4_full", bus.full, 1);
        check("t4_count16", bus.count, 16);
        check("t4_no_ovr_yet", ovr_n - o0, 0);
      end
    end
    check("t4_overrun", ovr_n - o0, exp_ovr);
    check("t4_count_after", bus.count, 16);
    drain("t4");

    // 5: full FIFO, pop in the push cycle of 0x77
    for (int i = 0; i < 16; i++) send_good(8'h20 + 8'(i), 1'b0);
    o0 = ovr_n;
    send_good(8'h77, 1'b1);
    check("t5_no_overrun", ovr_n - o0, 0);
    check("t5_count", bus.count, 16);
    drain("t5");

    // 6: reset in the middle of 0xFF, then 0x81 only
    f0 = ferr_n;
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("t6_rst_busy", bus.rx_busy, 0);
    check("t6_rst_count", bus.count, 0);
    repeat (6 * CPB) @(negedge clk);
    send_good(8'h81, 1'b0);
    check("t6_ferr", ferr_n - f0, 0);
    drain("t6");
`ifdef UART_RX_PARITY_EN
    p0 = perr_n;
    send_frame(1'b0, CPB, 8'h81, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("t6_parity_err", perr_n - p0, 1);
    check("t6_parity_count", bus.count, 0);
`else
    p0 = perr_n;
    check("t6_no_parity_err", perr_n - p0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
